// File: rtl/tl_ul_arbiter_2to1.sv
// Two-master to one-slave TL-UL arbiter: round-robin A-channel grant with burst
// locking, D-channel steering by source MSB, per-master outstanding throttling.

module tl_ul_arbiter_inflight #(
    parameter int unsigned MAX_INFLIGHT = 4,
    localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full
);
    logic [CW-1:0] count;

    // Simultaneous issue and retire leave the count untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc && !dec)
            count <= count + 1'b1;
        else if (dec && !inc && count != '0)
            count <= count - 1'b1;
    end

    assign full = (count >= CW'(MAX_INFLIGHT));

    decAtZero: assert property (@(posedge clock) disable iff (reset)
        !(dec && !inc && count == '0));
endmodule

module tl_ul_arbiter_2to1 #(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned SRC_W        = 4
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             m0_a_valid,
    output logic             m0_a_ready,
    input  logic [2:0]       m0_a_opcode,
    input  logic [2:0]       m0_a_param,
    input  logic [2:0]       m0_a_size,
    input  logic [SRC_W-1:0] m0_a_source,
    input  logic [31:0]      m0_a_address,
    input  logic [3:0]       m0_a_mask,
    input  logic [31:0]      m0_a_data,

    input  logic             m1_a_valid,
    output logic             m1_a_ready,
    input  logic [2:0]       m1_a_opcode,
    input  logic [2:0]       m1_a_param,
    input  logic [2:0]       m1_a_size,
    input  logic [SRC_W-1:0] m1_a_source,
    input  logic [31:0]      m1_a_address,
    input  logic [3:0]       m1_a_mask,
    input  logic [31:0]      m1_a_data,

    output logic             s_a_valid,
    input  logic             s_a_ready,
    output logic [2:0]       s_a_opcode,
    output logic [2:0]       s_a_param,
    output logic [2:0]       s_a_size,
    output logic [SRC_W:0]   s_a_source,
    output logic [31:0]      s_a_address,
    output logic [3:0]       s_a_mask,
    output logic [31:0]      s_a_data,

    input  logic             s_d_valid,
    output logic             s_d_ready,
    input  logic [2:0]       s_d_opcode,
    input  logic [1:0]       s_d_param,
    input  logic [2:0]       s_d_size,
    input  logic [SRC_W:0]   s_d_source,
    input  logic             s_d_sink,
    input  logic             s_d_denied,
    input  logic             s_d_corrupt,
    input  logic [31:0]      s_d_data,

    output logic             m0_d_valid,
    input  logic             m0_d_ready,
    output logic [2:0]       m0_d_opcode,
    output logic [1:0]       m0_d_param,
    output logic [2:0]       m0_d_size,
    output logic [SRC_W-1:0] m0_d_source,
    output logic             m0_d_sink,
    output logic             m0_d_denied,
    output logic             m0_d_corrupt,
    output logic [31:0]      m0_d_data,

    output logic             m1_d_valid,
    input  logic             m1_d_ready,
    output logic [2:0]       m1_d_opcode,
    output logic [1:0]       m1_d_param,
    output logic [2:0]       m1_d_size,
    output logic [SRC_W-1:0] m1_d_source,
    output logic             m1_d_sink,
    output logic             m1_d_denied,
    output logic             m1_d_corrupt,
    output logic [31:0]      m1_d_data
);
    typedef struct packed {
        logic [2:0]       opcode;
        logic [2:0]       param;
        logic [2:0]       size;
        logic [SRC_W-1:0] source;
        logic [31:0]      address;
        logic [3:0]       mask;
        logic [31:0]      data;
    } aReq_t;

    function automatic logic [5:0] aBeats(input logic [2:0] opcode, input logic [2:0] size);
        if ((opcode == 3'd0 || opcode == 3'd1) && size > 3'd2)
            return 6'd1 << (size - 3'd2);
        return 6'd1;
    endfunction

    function automatic logic [5:0] dBeats(input logic [2:0] opcode, input logic [2:0] size);
        if (opcode == 3'd1 && size > 3'd2)
            return 6'd1 << (size - 3'd2);
        return 6'd1;
    endfunction

    aReq_t [1:0] mReq;
    logic  [1:0] mAValid, mAReady, mDReady, mDValid;
    logic  [1:0] elig, full, inc, dec;

    logic       lockQ, lockD, lockIdQ, lockIdD;
    logic       lastGrantQ, lastGrantD;
    logic       holdQ, holdD, holdIdQ, holdIdD;
    logic [5:0] aBeatCntQ, aBeatCntD, dBeatCntQ, dBeatCntD;
    logic [5:0] aBeatsNow, dBeatsNow;
    logic       grant, aFire, aFirst, dId, dFire, dLast;

    assign mReq[0] = '{opcode: m0_a_opcode, param: m0_a_param, size: m0_a_size,
                       source: m0_a_source, address: m0_a_address, mask: m0_a_mask,
                       data: m0_a_data};
    assign mReq[1] = '{opcode: m1_a_opcode, param: m1_a_param, size: m1_a_size,
                       source: m1_a_source, address: m1_a_address, mask: m1_a_mask,
                       data: m1_a_data};
    assign mAValid = {m1_a_valid, m0_a_valid};
    assign mDReady = {m1_d_ready, m0_d_ready};

    assign dId       = s_d_source[SRC_W];
    assign aBeatsNow = aBeats(mReq[grant].opcode, mReq[grant].size);
    assign dBeatsNow = dBeats(s_d_opcode, s_d_size);

    // Per-master eligibility, throttling and D steering
    for (genvar g = 0; g < 2; g++) begin : gMaster
        assign elig[g]    = mAValid[g] & (~full[g] | (lockQ & (lockIdQ == 1'(g))));
        assign mAReady[g] = ~reset & s_a_ready & (grant == 1'(g)) & elig[g];
        assign mDValid[g] = ~reset & s_d_valid & (dId == 1'(g));
        assign inc[g]     = aFirst & (grant == 1'(g));
        assign dec[g]     = dFire & dLast & (dId == 1'(g));

        tl_ul_arbiter_inflight #(.MAX_INFLIGHT(MAX_INFLIGHT)) uInflight (
            .clock (clock),
            .reset (reset),
            .inc   (inc[g]),
            .dec   (dec[g]),
            .full  (full[g])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lockQ      <= 1'b0;
            lockIdQ    <= 1'b0;
            lastGrantQ <= 1'b1;
            holdQ      <= 1'b0;
            holdIdQ    <= 1'b0;
            aBeatCntQ  <= '0;
            dBeatCntQ  <= '0;
        end else begin
            lockQ      <= lockD;
            lockIdQ    <= lockIdD;
            lastGrantQ <= lastGrantD;
            holdQ      <= holdD;
            holdIdQ    <= holdIdD;
            aBeatCntQ  <= aBeatCntD;
            dBeatCntQ  <= dBeatCntD;
        end
    end

    always_comb begin
        lockD      = lockQ;
        lockIdD    = lockIdQ;
        lastGrantD = lastGrantQ;
        aBeatCntD  = aBeatCntQ;
        dBeatCntD  = dBeatCntQ;
        // A stalled offer keeps its grant until it is accepted.
        holdD      = s_a_valid & ~s_a_ready;
        holdIdD    = grant;
        if (aFirst) begin
            lastGrantD = grant;
            if (aBeatsNow > 6'd1) begin
                lockD     = 1'b1;
                lockIdD   = grant;
                aBeatCntD = aBeatsNow - 6'd1;
            end
        end else if (aFire) begin
            aBeatCntD = aBeatCntQ - 6'd1;
            if (aBeatCntQ == 6'd1)
                lockD = 1'b0;
        end
        if (dFire)
            dBeatCntD = (dBeatCntQ == '0) ? dBeatsNow - 6'd1 : dBeatCntQ - 6'd1;
    end

    always_comb begin
        if (lockQ)
            grant = lockIdQ;
        else if (holdQ)
            grant = holdIdQ;
        else if (elig[0] && elig[1])
            grant = ~lastGrantQ;
        else
            grant = elig[1];

        s_a_valid   = ~reset & elig[grant];
        s_a_opcode  = mReq[grant].opcode;
        s_a_param   = mReq[grant].param;
        s_a_size    = mReq[grant].size;
        s_a_source  = {grant, mReq[grant].source};
        s_a_address = mReq[grant].address;
        s_a_mask    = mReq[grant].mask;
        s_a_data    = mReq[grant].data;
        aFire       = s_a_valid & s_a_ready;
        aFirst      = aFire & ~lockQ;

        s_d_ready   = ~reset & mDReady[dId];
        dFire       = s_d_valid & s_d_ready;
        dLast       = (dBeatCntQ == '0) ? (dBeatsNow == 6'd1) : (dBeatCntQ == 6'd1);
    end

    assign m0_a_ready   = mAReady[0];
    assign m1_a_ready   = mAReady[1];
    assign m0_d_valid   = mDValid[0];
    assign m1_d_valid   = mDValid[1];

    assign m0_d_opcode  = s_d_opcode;
    assign m0_d_param   = s_d_param;
    assign m0_d_size    = s_d_size;
    assign m0_d_source  = s_d_source[SRC_W-1:0];
    assign m0_d_sink    = s_d_sink;
    assign m0_d_denied  = s_d_denied;
    assign m0_d_corrupt = s_d_corrupt;
    assign m0_d_data    = s_d_data;

    assign m1_d_opcode  = s_d_opcode;
    assign m1_d_param   = s_d_param;
    assign m1_d_size    = s_d_size;
    assign m1_d_source  = s_d_source[SRC_W-1:0];
    assign m1_d_sink    = s_d_sink;
    assign m1_d_denied  = s_d_denied;
    assign m1_d_corrupt = s_d_corrupt;
    assign m1_d_data    = s_d_data;
endmodule

// File: doc/tl_ul_arbiter_2to1.md
Name: tl_ul_arbiter_2to1

Overview:
- Two-master to one-slave TileLink arbiter for the 32-bit core/peripheral fabric.
- Shares one downstream A-channel sink between two upstream masters, using round-robin arbitration with burst locking.
- Steers D-channel responses back to the originating master by a source-ID prefix bit.
- Counts outstanding transactions per master and throttles a master at its limit.
- Zero-latency combinational datapath; all state is arbitration, beat counting and in-flight counts.

Parameters:
MAX_INFLIGHT, 4, maximum outstanding A transactions per master (1..15)
SRC_W, 4, upstream source width; downstream source width is SRC_W+1

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-high reset
mN_a_valid / mN_a_ready  in / out  1 each  upstream A handshake, N=0,1
mN_a_opcode, mN_a_param, mN_a_size  in  3 each  upstream A fields
mN_a_source  in  SRC_W  upstream A source
mN_a_address, mN_a_data  in  32 each  upstream A address and data
mN_a_mask  in  4  upstream A byte mask
s_a_valid / s_a_ready  out / in  1 each  downstream A handshake
s_a_opcode/param/size/address/mask/data  out  as upstream  downstream A fields
s_a_source  out  SRC_W+1  downstream A source, {master_id, mN_a_source}
s_d_valid / s_d_ready  in / out  1 each  downstream D handshake
s_d_opcode, s_d_size  in  3 each  downstream D fields
s_d_param  in  2  downstream D param
s_d_source  in  SRC_W+1  downstream D source
s_d_sink, s_d_denied, s_d_corrupt  in  1 each  downstream D flags
s_d_data  in  32  downstream D data
mN_d_valid / mN_d_ready  out / in  1 each  upstream D handshake
mN_d_opcode, mN_d_param, mN_d_size, mN_d_sink, mN_d_denied, mN_d_corrupt, mN_d_data  out  as s_d  upstream D fields
mN_d_source  out  SRC_W  s_d_source[SRC_W-1:0]

Behaviour:
- Beat counts:
  - A beats = 2^(size-2) when opcode is PutFull(0) or PutPartial(1) and size>2; otherwise 1.
  - D beats = 2^(size-2) when opcode is AccessAckData(1) and size>2; otherwise 1.
- Eligibility: master N is eligible when mN_a_valid=1 and inflight_N < MAX_INFLIGHT. A master already locked mid-burst stays eligible regardless of its count.
- Grant when unlocked:
  - One eligible master: grant it.
  - Both eligible: grant the master other than last_grant.
  - Grant is combinational, with no added cycle.
- Lock: a first-beat fire (s_a_valid & s_a_ready) with A beats > 1 sets lock to that master.
  - a_beat_cnt loads beats-1 and decrements on each fire.
  - Lock clears on the fire where a_beat_cnt==1.
  - While locked, the other master is never granted.
- last_grant updates to the granted master on every first-beat fire.
- A datapath:
  - s_a_* = granted master's fields.
  - s_a_valid = granted master's mN_a_valid.
  - mN_a_ready = s_a_ready & (grant==N).
  - The non-granted master's ready is 0.
  - No eligible master: s_a_valid=0.
- D routing:
  - Target id = s_d_source[SRC_W].
  - mN_d_valid = s_d_valid & (id==N).
  - s_d_ready = m{id}_d_ready.
  - d_beat_cnt tracks the multi-beat response; the last beat is when the count reaches 1, or a single-beat response.
- In-flight counters, width clog2(MAX_INFLIGHT+1):
  - +1 on master N's A first-beat fire.
  - -1 on the last D beat fire routed to N.
  - Both in the same cycle: unchanged.
  - Decrement at 0 is illegal; hold at 0 and flag via simulation assertion.
- Reset (asynchronous):
  - lock=0, last_grant=1 (so m0 wins first tie), a_beat_cnt=0, d_beat_cnt=0, inflight=0.
  - All valid/ready outputs are 0 while reset=1.
  - Reset mid-burst discards the lock and counts immediately; no partial beat is replayed.
- Protocol: A inputs are assumed stable while valid & !ready. The arbiter never changes grant while the granted master's valid is high and not accepted. The grant is registered against last_grant, so an unlocked re-evaluation only happens after a fire.

Test Plan:
- Both masters issue single-beat Get continuously, s_a_ready=1: grants alternate m0,m1,m0,…; s_a_source[4] toggles 0,1,0 each cycle.
- m0 issues PutFull size=4 (4 beats) while m1 valid: m0 holds 4 consecutive fires; m1 granted on cycle 5.
- MAX_INFLIGHT=4, m0 sends 4 Gets with no D returned: 5th Get is blocked (m0_a_ready=0). One AccessAckData with source=5'b0_0011 returned → ready rises next cycle, m0_d_source=4'h3.
- D AccessAckData size=3 with source MSB=1 and m1_d_ready toggling: 2 beats delivered only to m1; m0_d_valid stays 0; inflight_1 decrements once, after beat 2.
- A first-beat fire for m0 and last D beat for m0 in the same cycle: inflight_0 unchanged.
- Reset asserted after beat 2 of a 4-beat PutFull: outputs drop to 0 asynchronously; after release, m0 wins the first tie and the counters read 0.
